fsub_arbiter: RTL and testbench
===============================

FSUB_ARBITER -- requirements
Module: fsub_arbiter

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 2, giving the fixed issue-to-result latency in cycles of the attached fsub_p2 datapath.
REQ-002 SHALL have parameter RBUF_DEPTH, default 2, giving the per-requester result buffer depth and credit limit.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 a_valid / b_valid  input  1  requester A/B operation request.
REQ-006 a_ready / b_ready  output  1  request accepted this cycle when valid and ready are both high.
REQ-007 a_x1, a_x2 / b_x1, b_x2  input  32  IEEE-754 single operands; the result is x1 - x2.
REQ-008 a_rvalid / b_rvalid  output  1  result available.
REQ-009 a_rready / b_rready  input  1  result consumed when rvalid and rready are both high.
REQ-010 a_y / b_y  output  32  result word.
REQ-011 a_ovf / b_ovf  output  1  overflow flag paired with the result.
REQ-012 fsub_x1, fsub_x2  output  32  operands driven to the shared fsub_p2 instance.
REQ-013 fsub_y  input  32  fsub_p2 result.
REQ-014 fsub_ovf  input  1  fsub_p2 overflow flag.
REQ-015 busy  output  1  high while any operation is in flight or any result is buffered.

Function
REQ-016 SHALL track one credit counter per requester, range 0..RBUF_DEPTH, counting in-flight plus buffered results.
REQ-017 A requester SHALL be eligible only when its valid is high and its credit is below RBUF_DEPTH.
REQ-018 SHALL grant at most one issue per cycle, combinationally.
REQ-019 With both requesters eligible, the grant SHALL go to the round-robin pointer holder; with one eligible, that one wins.
REQ-020 After an issue, the pointer SHALL move to the requester not granted; with no issue, the pointer SHALL hold.
REQ-021 x_ready SHALL equal the grant to x, and SHALL never depend on x_valid of the other requester except through arbitration.
REQ-022 fsub_x1/fsub_x2 SHALL carry the granted requester's operands; with no grant they SHALL be 32'h0.
REQ-023 SHALL keep a PIPE_LAT-deep shift register of {valid, tag}, with tag 0 = A and 1 = B, loaded with the issue at stage 0.
REQ-024 When the last stage is valid, fsub_y and fsub_ovf in that cycle SHALL be written into the tagged requester's result FIFO.
REQ-025 Issue in cycle t SHALL give x_rvalid high in cycle t+PIPE_LAT+1 at the earliest (3 with defaults), with results returned in issue order per requester.
REQ-026 Credit SHALL increment on issue and decrement on a result handshake; both in the same cycle leave it unchanged.
REQ-027 A result FIFO SHALL never overflow; a FIFO write while the FIFO is full is a design error, and the verification bench SHALL assert on it.
REQ-028 x_y and x_ovf SHALL come from the FIFO head and stay stable while x_rvalid is high and x_rready is low.
REQ-029 A FIFO read and a FIFO write in the same cycle SHALL both take effect, including when the FIFO is empty or full.
REQ-030 busy SHALL equal the OR of the shift-register valid bits and both FIFOs being non-empty.

Reset
REQ-031 With rstn low at a clock edge, the following SHALL clear: both credits, both FIFOs (rvalid = 0), all shift-register valid bits, and the pointer (set to A). busy SHALL be 0.
REQ-032 Reset mid-operation SHALL discard in-flight and buffered results with no late rvalid; the shared fsub_p2 SHALL use the same rstn.
REQ-033 While rstn is low, a_ready and b_ready SHALL be 0.

Verification
REQ-034 A issues x1=3F800000, x2=3F000000 in cycle t -> a_rvalid is high in t+3 with a_y=3F000000, a_ovf=0, and b_rvalid stays 0.
REQ-035 A and B both valid in the same cycle after reset -> A is granted first and B next cycle; the results arrive in cycles t+3 and t+4 on the correct ports.
REQ-036 A issues x1=7F7FFFFF, x2=FF7FFFFF -> a_y=7F800000, a_ovf=1.
REQ-037 a_rready=0 with a_valid held high -> two issues, then a_ready=0; one a_rready pulse -> exactly one further issue, and no FIFO overflow occurs.
REQ-038 rstn pulsed low one cycle after two issues -> no rvalid follows, busy=0, and the next A issue returns the correct result at t+3.
REQ-039 A and B continuously valid with rready=1 -> the grants strictly alternate A, B, A, B, and throughput is 1 result per cycle.

Source files
------------

// File: rtl/fsub_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared fsub_p2 datapath.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface fsub_arbiter_if;
  logic        a_valid, a_ready, a_rvalid, a_rready, a_ovf;
  logic [31:0] a_x1, a_x2, a_y;
  logic        b_valid, b_ready, b_rvalid, b_rready, b_ovf;
  logic [31:0] b_x1, b_x2, b_y;
  logic [31:0] fsub_x1, fsub_x2, fsub_y;
  logic        fsub_ovf;
  logic        busy;

  modport slave (
    input  a_valid, a_x1, a_x2, a_rready,
    input  b_valid, b_x1, b_x2, b_rready,
    input  fsub_y, fsub_ovf,
    output a_ready, a_rvalid, a_y, a_ovf,
    output b_ready, b_rvalid, b_y, b_ovf,
    output fsub_x1, fsub_x2, busy
  );

  modport master (
    output a_valid, a_x1, a_x2, a_rready,
    output b_valid, b_x1, b_x2, b_rready,
    output fsub_y, fsub_ovf,
    input  a_ready, a_rvalid, a_y, a_ovf,
    input  b_ready, b_rvalid, b_y, b_ovf,
    input  fsub_x1, fsub_x2, busy
  );
endinterface

// File: rtl/fsub_arbiter.sv
// Round-robin sharing of one pipelined fsub_p2 between requesters A and B, with
// credit-limited per-requester result FIFOs so a stalled consumer can never overflow.
module fsub_arbiter #(
  parameter int PIPE_LAT   = 2,
  parameter int RBUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rstn,
  fsub_arbiter_if.slave bus
);

  localparam int CW = $clog2(RBUF_DEPTH + 1);
  localparam int PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RBUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RBUF_DEPTH - 1);

  // Index 0 is requester A, index 1 is requester B (matches the pipeline tag).
  logic [1:0]  req_valid, res_ready, eligible, grant, res_valid, res_ovf;
  logic [31:0] req_x1 [2];
  logic [31:0] req_x2 [2];
  logic [31:0] res_y  [2];
  logic        issue, issue_tag;
  logic        rr_ptr_reg;
  logic [PIPE_LAT-1:0] pipe_valid_reg, pipe_tag_reg;

  assign req_valid = {bus.b_valid, bus.a_valid};
  assign res_ready = {bus.b_rready, bus.a_rready};
  assign req_x1[0] = bus.a_x1;
  assign req_x1[1] = bus.b_x1;
  assign req_x2[0] = bus.a_x2;
  assign req_x2[1] = bus.b_x2;

  // Reset gates the grant so ready stays low throughout reset.
  always_comb begin
    grant = 2'b00;
    if (rstn) begin
      if (eligible == 2'b11) grant = rr_ptr_reg ? 2'b10 : 2'b01;
      else                   grant = eligible;
    end
  end

  assign issue     = |grant;
  assign issue_tag = grant[1];

  assign bus.a_ready = grant[0];
  assign bus.b_ready = grant[1];
  assign bus.fsub_x1 = grant[0] ? req_x1[0] : (grant[1] ? req_x1[1] : 32'h0);
  assign bus.fsub_x2 = grant[0] ? req_x2[0] : (grant[1] ? req_x2[1] : 32'h0);

  always_ff @(posedge clk) begin
    if (!rstn)      rr_ptr_reg <= 1'b0;
    else if (issue) rr_ptr_reg <= ~issue_tag;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_valid_reg[0] <= 1'b0;
      pipe_tag_reg[0]   <= 1'b0;
    end else begin
      pipe_valid_reg[0] <= issue;
      pipe_tag_reg[0]   <= issue_tag;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < PIPE_LAT; gi++) begin : gen_pipe
      always_ff @(posedge clk) begin
        if (!rstn) begin
          pipe_valid_reg[gi] <= 1'b0;
          pipe_tag_reg[gi]   <= 1'b0;
        end else begin
          pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
          pipe_tag_reg[gi]   <= pipe_tag_reg[gi-1];
        end
      end
    end

    for (gi = 0; gi < 2; gi++) begin : gen_req
      logic [CW-1:0] credit_reg, count_reg;
      logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [32:0]   mem [RBUF_DEPTH];
      logic [32:0]   head;
      logic          wr_en, rd_en;

      assign wr_en         = pipe_valid_reg[PIPE_LAT-1] && (pipe_tag_reg[PIPE_LAT-1] == 1'(gi));
      assign res_valid[gi] = (count_reg != '0);
      assign rd_en         = res_valid[gi] && res_ready[gi];
      // Credit covers in-flight plus buffered results, so a write always finds room.
      assign eligible[gi]  = req_valid[gi] && (credit_reg < CREDIT_MAX);

      always_ff @(posedge clk) begin
        if (!rstn) begin
          credit_reg <= '0;
          count_reg  <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          credit_reg <= credit_reg + CW'(grant[gi]) - CW'(rd_en);
          count_reg  <= count_reg + CW'(wr_en) - CW'(rd_en);
          if (wr_en) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
          if (rd_en) rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= {bus.fsub_ovf, bus.fsub_y};
      end

      assign head        = mem[rd_ptr_reg];
      assign res_y[gi]   = head[31:0];
      assign res_ovf[gi] = head[32];
    end
  endgenerate

  assign bus.a_rvalid = res_valid[0];
  assign bus.b_rvalid = res_valid[1];
  assign bus.a_y      = res_y[0];
  assign bus.b_y      = res_y[1];
  assign bus.a_ovf    = res_ovf[0];
  assign bus.b_ovf    = res_ovf[1];
  assign bus.busy     = (|pipe_valid_reg) || (|res_valid);

endmodule

// File: tb/tb_fsub_arbiter.sv
// Bench for fsub_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of outstanding results per requester.
module tb_fsub_arbiter;
  localparam int PIPE_LAT   = 2;
  localparam int RBUF_DEPTH = 2;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    int          avail;
  } res_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fsub_arbiter_if bus ();

  fsub_arbiter #(.PIPE_LAT(PIPE_LAT), .RBUF_DEPTH(RBUF_DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Stand-in for fsub_p2: exact for the directed operands, a deterministic mix otherwise.
  function automatic logic [32:0] fsub_ref(input logic [31:0] x1, input logic [31:0] x2);
    if (x1 == 32'h3F800000 && x2 == 32'h3F000000) return {1'b0, 32'h3F000000};
    if (x1 == 32'h7F7FFFFF && x2 == 32'hFF7FFFFF) return {1'b1, 32'h7F800000};
    return {^(x1 ^ x2), x1 - x2};
  endfunction

  logic [32:0] fs_pipe [PIPE_LAT];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < PIPE_LAT; k++) fs_pipe[k] <= '0;
    end else begin
      fs_pipe[0] <= fsub_ref(bus.fsub_x1, bus.fsub_x2);
      for (int k = 1; k < PIPE_LAT; k++) fs_pipe[k] <= fs_pipe[k-1];
    end
  end
  assign bus.fsub_y   = fs_pipe[PIPE_LAT-1][31:0];
  assign bus.fsub_ovf = fs_pipe[PIPE_LAT-1][32];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int prefer = 0;
  int obs_out [2];
  res_t q [2][$];

  logic [1:0]  obs_ready, obs_rvalid, obs_ovf, obs_hs;
  logic [31:0] obs_y [2];
  logic        obs_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: inputs already driven, check mid-cycle, then advance the model.
  task automatic tick();
    logic [1:0]  v, rr, elig, g, exp_rv;
    logic [31:0] ex1, ex2;
    logic [32:0] r;
    res_t        e;
    #3;
    v  = {bus.b_valid, bus.a_valid};
    rr = {bus.b_rready, bus.a_rready};
    for (int i = 0; i < 2; i++) begin
      elig[i]   = v[i] && (q[i].size() < RBUF_DEPTH);
      exp_rv[i] = (q[i].size() > 0) && (q[i][0].avail <= cyc);
    end
    g = 2'b00;
    if (rstn) g = (elig == 2'b11) ? ((prefer != 0) ? 2'b10 : 2'b01) : elig;
    ex1 = g[0] ? bus.a_x1 : (g[1] ? bus.b_x1 : 32'h0);
    ex2 = g[0] ? bus.a_x2 : (g[1] ? bus.b_x2 : 32'h0);

    obs_ready  = {bus.b_ready, bus.a_ready};
    obs_rvalid = {bus.b_rvalid, bus.a_rvalid};
    obs_ovf    = {bus.b_ovf, bus.a_ovf};
    obs_y[0]   = bus.a_y;
    obs_y[1]   = bus.b_y;
    obs_busy   = bus.busy;
    obs_hs     = obs_rvalid & rr;

    check("a_ready", obs_ready[0], g[0]);
    check("b_ready", obs_ready[1], g[1]);
    check("fsub_x1", bus.fsub_x1, ex1);
    check("fsub_x2", bus.fsub_x2, ex2);
    check("a_rvalid", obs_rvalid[0], exp_rv[0]);
    check("b_rvalid", obs_rvalid[1], exp_rv[1]);
    if (exp_rv[0]) begin
      check("a_y", obs_y[0], q[0][0].y);
      check("a_ovf", obs_ovf[0], q[0][0].ovf);
    end
    if (exp_rv[1]) begin
      check("b_y", obs_y[1], q[1][0].y);
      check("b_ovf", obs_ovf[1], q[1][0].ovf);
    end
    check("busy", obs_busy, (q[0].size() + q[1].size()) > 0);

    // Outstanding count seen purely at the DUT ports; exceeding depth means a FIFO overflow.
    for (int i = 0; i < 2; i++) begin
      obs_out[i] += int'(obs_ready[i] && v[i]) - int'(obs_hs[i]);
      check(i == 0 ? "a_fifo_ovf" : "b_fifo_ovf", obs_out[i] <= RBUF_DEPTH, 1'b1);
    end
    r = fsub_ref(ex1, ex2);

    @(posedge clk);
    if (!rstn) begin
      q[0].delete();
      q[1].delete();
      prefer     = 0;
      obs_out[0] = 0;
      obs_out[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (exp_rv[i] && rr[i]) begin
          e = q[i].pop_front();
          $display("cyc %0d: %s result y=%h ovf=%b", cyc, (i == 0) ? "A" : "B", e.y, e.ovf);
        end
      end
      if (g != 2'b00) begin
        e.y     = r[31:0];
        e.ovf   = r[32];
        e.avail = cyc + PIPE_LAT + 1;
        q[g[1] ? 1 : 0].push_back(e);
        prefer = g[0] ? 1 : 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;  bus.b_valid = 1'b0;
    bus.a_rready = 1'b1; bus.b_rready = 1'b1;
    bus.a_x1 = 32'h0; bus.a_x2 = 32'h0;
    bus.b_x1 = 32'h0; bus.b_x2 = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    obs_out[0] = 0;
    obs_out[1] = 0;
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Ready held low during reset even with both requesting.
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    tick();
    check("rst_ready", obs_ready, 2'b00);
    idle();
    rstn = 1'b1;
    tick();
    check("rst_busy", obs_busy, 1'b0);
    check("rst_rvalid", obs_rvalid, 2'b00);

    // Single A issue, result exactly three cycles later.
    do_reset();
    bus.a_valid = 1'b1; bus.a_x1 = 32'h3F800000; bus.a_x2 = 32'h3F000000;
    tick();
    check("d1_issue", obs_ready, 2'b01);
    bus.a_valid = 1'b0;
    n = 0;
    repeat (2) begin tick(); n += int'(obs_rvalid != 2'b00); end
    check("d1_early", n, 0);
    tick();
    check("d1_rvalid", obs_rvalid, 2'b01);
    check("d1_y", obs_y[0], 32'h3F000000);
    check("d1_ovf", obs_ovf[0], 1'b0);

    // Simultaneous requests after reset: A first, then B.
    do_reset();
    bus.a_valid = 1'b1; bus.a_x1 = $urandom; bus.a_x2 = $urandom;
    bus.b_valid = 1'b1; bus.b_x1 = $urandom; bus.b_x2 = $urandom;
    tick();
    check("d2_grant_a", obs_ready, 2'b01);
    bus.a_valid = 1'b0;
    tick();
    check("d2_grant_b", obs_ready, 2'b10);
    bus.b_valid = 1'b0;
    tick();
    tick();
    check("d2_res_a", obs_rvalid, 2'b01);
    tick();
    check("d2_res_b", obs_rvalid, 2'b10);

    // Overflow operands.
    idle();
    bus.a_valid = 1'b1; bus.a_x1 = 32'h7F7FFFFF; bus.a_x2 = 32'hFF7FFFFF;
    tick();
    bus.a_valid = 1'b0;
    repeat (2) tick();
    tick();
    check("d3_rvalid", obs_rvalid[0], 1'b1);
    check("d3_y", obs_y[0], 32'h7F800000);
    check("d3_ovf", obs_ovf[0], 1'b1);

    // Back-pressure: credits stop issue at depth, one pop allows exactly one more.
    do_reset();
    bus.a_rready = 1'b0;
    bus.a_valid = 1'b1; bus.a_x1 = 32'h12345678; bus.a_x2 = 32'h00000678;
    n = 0;
    repeat (6) begin tick(); n += int'(obs_ready[0]); end
    check("d4_fill", n, 2);
    bus.a_rready = 1'b1;
    tick();
    n = int'(obs_ready[0]);
    bus.a_rready = 1'b0;
    repeat (5) begin tick(); n += int'(obs_ready[0]); end
    check("d4_pulse", n, 1);
    bus.a_valid = 1'b0; bus.a_rready = 1'b1;
    repeat (6) tick();
    check("d4_drain", obs_busy, 1'b0);

    // Reset after two issues discards them.
    do_reset();
    bus.a_valid = 1'b1; bus.a_x1 = $urandom; bus.a_x2 = $urandom;
    repeat (2) tick();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n = 0;
    repeat (5) begin tick(); n += int'(obs_rvalid != 2'b00); end
    check("d5_no_rvalid", n, 0);
    check("d5_busy", obs_busy, 1'b0);
    bus.a_valid = 1'b1; bus.a_x1 = 32'h3F800000; bus.a_x2 = 32'h3F000000;
    tick();
    bus.a_valid = 1'b0;
    repeat (2) tick();
    tick();
    check("d5_rvalid", obs_rvalid, 2'b01);
    check("d5_y", obs_y[0], 32'h3F000000);

    // Continuous traffic: strict alternation and one result per cycle.
    do_reset();
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      bus.a_x1 = $urandom; bus.a_x2 = $urandom;
      bus.b_x1 = $urandom; bus.b_x2 = $urandom;
      tick();
      check("d6_alt", obs_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k >= 4) n += int'(obs_hs[0]) + int'(obs_hs[1]);
    end
    check("d6_tput", n, 12);
    idle();
    repeat (6) tick();

    // Random traffic with occasional resets.
    for (int k = 0; k < 700; k++) begin
      bus.a_valid  = ($urandom_range(0, 3) != 0);
      bus.b_valid  = ($urandom_range(0, 3) != 0);
      bus.a_rready = ($urandom_range(0, 3) != 0);
      bus.b_rready = ($urandom_range(0, 2) != 0);
      bus.a_x1 = $urandom; bus.a_x2 = $urandom;
      bus.b_x1 = $urandom; bus.b_x2 = $urandom;
      rstn = ($urandom_range(0, 149) != 0);
      tick();
    end
    rstn = 1'b1;
    idle();
    repeat (8) tick();
    check("end_busy", obs_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end
endmodule
